// File: rtl/des_key_schedule.sv
// DES key schedule: latches a key, applies PC-1, and issues the 16 PC-2 round
// subkeys in encrypt (K1..K16) or decrypt (K16..K1) order over valid/ready.
module des_key_schedule #(
   parameter int PARITY_CHECK = 0
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        START,
   input  logic [63:0] KEY,
   input  logic        DECRYPT,
   output logic [47:0] SUBKEY,
   output logic        SUBKEY_VALID,
   input  logic        SUBKEY_READY,
   output logic [3:0]  ROUND,
   output logic        BUSY,
   output logic        DONE,
   output logic        KEY_ERR
);

   typedef enum logic {IDLE, RUN} state_t;

   // Table entries use the DES bit numbering: bit 1 is the MSB of the source.
   localparam int PC1_TAB [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TAB [0:47] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   state_t      state_reg, state_next;
   logic [27:0] c_reg, c_next, d_reg, d_next;
   logic [47:0] subkey_reg, subkey_next;
   logic [3:0]  round_reg, round_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        valid_reg, valid_next;
   logic        busy_reg, busy_next;
   logic        done_reg, done_next;
   logic        key_err_reg, key_err_next;
   logic        decrypt_reg, decrypt_next;

   logic [55:0] pc1_key;
   logic [7:0]  byte_odd;
   logic        key_ok;
   logic [27:0] c_cand, d_cand;
   logic [55:0] cd_cand;
   logic [47:0] pc2_cand;

   // Rotation amount for a 0-based round index: one position for rounds 1, 2, 9, 16.
   function automatic logic shift_two(input logic [3:0] idx);
      return !(idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15);
   endfunction

   function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
      return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
   endfunction

   function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
      return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 56; gi++) begin : g_pc1
         assign pc1_key[55-gi] = KEY[64-PC1_TAB[gi]];
      end
      for (gi = 0; gi < 8; gi++) begin : g_parity
         assign byte_odd[gi] = ^KEY[gi*8 +: 8];
      end
      for (gi = 0; gi < 48; gi++) begin : g_pc2
         assign pc2_cand[47-gi] = cd_cand[56-PC2_TAB[gi]];
      end
   endgenerate

   assign key_ok = (PARITY_CHECK == 0) || (&byte_odd);

   // C/D for the subkey that would be loaded next: the first subkey in IDLE,
   // otherwise one schedule step on from the currently issued subkey.
   always_comb begin
      c_cand = c_reg;
      d_cand = d_reg;
      if (state_reg == IDLE) begin
         if (DECRYPT) begin
            c_cand = pc1_key[55:28];
            d_cand = pc1_key[27:0];
         end else begin
            c_cand = rotl(pc1_key[55:28], 1'b0);
            d_cand = rotl(pc1_key[27:0], 1'b0);
         end
      end else if (decrypt_reg) begin
         c_cand = rotr(c_reg, shift_two(round_reg));
         d_cand = rotr(d_reg, shift_two(round_reg));
      end else begin
         c_cand = rotl(c_reg, shift_two(round_reg + 4'd1));
         d_cand = rotl(d_reg, shift_two(round_reg + 4'd1));
      end
   end

   assign cd_cand = {c_cand, d_cand};

   always_comb begin
      state_next   = state_reg;
      c_next       = c_reg;
      d_next       = d_reg;
      subkey_next  = subkey_reg;
      round_next   = round_reg;
      cnt_next     = cnt_reg;
      valid_next   = valid_reg;
      busy_next    = busy_reg;
      decrypt_next = decrypt_reg;
      done_next    = 1'b0;
      key_err_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (START) begin
               if (!key_ok) begin
                  key_err_next = 1'b1;
               end else begin
                  state_next   = RUN;
                  c_next       = c_cand;
                  d_next       = d_cand;
                  subkey_next  = pc2_cand;
                  round_next   = DECRYPT ? 4'd15 : 4'd0;
                  cnt_next     = 4'd0;
                  valid_next   = 1'b1;
                  busy_next    = 1'b1;
                  decrypt_next = DECRYPT;
               end
            end
         end
         RUN: begin
            if (valid_reg && SUBKEY_READY) begin
               if (cnt_reg == 4'd15) begin
                  state_next = IDLE;
                  valid_next = 1'b0;
                  busy_next  = 1'b0;
                  done_next  = 1'b1;
               end else begin
                  c_next      = c_cand;
                  d_next      = d_cand;
                  subkey_next = pc2_cand;
                  cnt_next    = cnt_reg + 4'd1;
                  round_next  = decrypt_reg ? round_reg - 4'd1 : round_reg + 4'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_reg   <= IDLE;
         c_reg       <= '0;
         d_reg       <= '0;
         subkey_reg  <= '0;
         round_reg   <= '0;
         cnt_reg     <= '0;
         valid_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         key_err_reg <= 1'b0;
         decrypt_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         c_reg       <= c_next;
         d_reg       <= d_next;
         subkey_reg  <= subkey_next;
         round_reg   <= round_next;
         cnt_reg     <= cnt_next;
         valid_reg   <= valid_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         key_err_reg <= key_err_next;
         decrypt_reg <= decrypt_next;
      end
   end

   assign SUBKEY       = subkey_reg;
   assign SUBKEY_VALID = valid_reg;
   assign ROUND        = round_reg;
   assign BUSY         = busy_reg;
   assign DONE         = done_reg;
   assign KEY_ERR      = key_err_reg;

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: stimulus queues expected subkeys, a monitor pops
// and compares each accepted subkey and checks stability during READY stalls.
module tb_des_key_schedule;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [63:0] key;
   logic        decrypt;
   logic [47:0] subkey;
   logic        valid;
   logic        ready;
   logic [3:0]  round;
   logic        busy;
   logic        done;
   logic        key_err;

   des_key_schedule #(.PARITY_CHECK(1)) dut (
      .CLK          (clk),
      .RESET_N      (reset_n),
      .START        (start),
      .KEY          (key),
      .DECRYPT      (decrypt),
      .SUBKEY       (subkey),
      .SUBKEY_VALID (valid),
      .SUBKEY_READY (ready),
      .ROUND        (round),
      .BUSY         (busy),
      .DONE         (done),
      .KEY_ERR      (key_err)
   );

   localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_B = 64'h0101010101010101;

   // K1..K16 for KEY_A, hand-derived from the classic worked DES example.
   logic [47:0] ks [0:15] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
   };

   logic [51:0] exp_q [$];
   logic [51:0] mon_exp;
   logic [47:0] last_exp;
   logic [47:0] held_sk;
   logic [3:0]  held_rd;
   logic        hold_pending;
   int          n_checks;
   int          n_fail;
   int          accepts;
   int          run_base;
   int          done_pulses;
   int          key_err_pulses;
   logic        stall_mode;
   int          low_left;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // READY driver: always high, or random low bursts of 0-5 cycles.
   always begin
      @(posedge clk);
      #1;
      if (stall_mode) begin
         if (low_left > 0) begin
            ready = 1'b0;
            low_left--;
         end else begin
            ready = 1'b1;
            low_left = $urandom_range(0, 5);
         end
      end else begin
         ready = 1'b1;
      end
   end

   // Monitor: an accept happens at the next rising edge when valid & ready
   // are seen here and reset is not being applied.
   always @(negedge clk) begin
      if (reset_n && valid) begin
         if (hold_pending) begin
            check("stall_subkey", subkey, held_sk);
            check("stall_round", round, held_rd);
         end
         if (ready) begin
            check("queue_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               mon_exp = exp_q.pop_front();
               $display("accept round %0d subkey %h (expected round %0d subkey %h)",
                        round, subkey, mon_exp[51:48], mon_exp[47:0]);
               check("subkey", subkey, mon_exp[47:0]);
               check("round", round, mon_exp[51:48]);
            end
            accepts++;
         end
      end
      if (reset_n && done) done_pulses++;
      if (reset_n && key_err) key_err_pulses++;
      hold_pending = reset_n && valid && !ready;
      held_sk = subkey;
      held_rd = round;
   end

   task automatic issue(input logic [63:0] k, input logic dec, input int n_push);
      start   = 1'b1;
      key     = k;
      decrypt = dec;
      run_base = accepts;
      for (int i = 0; i < n_push; i++) begin
         int r;
         r = dec ? 15 - i : i;
         exp_q.push_back({r[3:0], ks[r]});
         last_exp = ks[r];
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      check("first_valid", valid, 1);
      check("busy_high", busy, 1);
      check("key_err_low", key_err, 0);
      check("done_low", done, 0);
   endtask

   task automatic finish_run(input int exp_cycles);
      int cyc;
      bit seen;
      cyc = 0;
      seen = 0;
      while (!seen && cyc < 400) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done) seen = 1;
      end
      check("done_seen", seen, 1);
      check("valid_after_done", valid, 0);
      check("busy_after_done", busy, 0);
      check("queue_empty", exp_q.size(), 0);
      check("accept_count", accepts - run_base, 16);
      check("subkey_hold", subkey, last_exp);
      if (exp_cycles >= 0) check("run_cycles", cyc, exp_cycles);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0; n_fail = 0; accepts = 0; run_base = 0;
      done_pulses = 0; key_err_pulses = 0;
      hold_pending = 1'b0; stall_mode = 1'b0; low_left = 0;
      last_exp = '0;
      reset_n = 1'b0; start = 1'b0; key = '0; decrypt = 1'b0; ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_subkey", subkey, 0);
      check("reset_valid", valid, 0);
      check("reset_round", round, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_key_err", key_err, 0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Encrypt, then decrypt with START in the DONE cycle.
      issue(KEY_A, 1'b0, 16);
      finish_run(16);
      issue(KEY_A, 1'b1, 16);
      finish_run(16);

      // Random READY stalls.
      stall_mode = 1'b1;
      issue(KEY_A, 1'b0, 16);
      finish_run(-1);
      stall_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Parity rejection, then a good key.
      start = 1'b1;
      key = 64'h0;
      decrypt = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("parity_key_err", key_err, 1);
      check("parity_busy", busy, 0);
      check("parity_valid", valid, 0);
      @(posedge clk);
      #1;
      check("parity_key_err_pulse", key_err, 0);
      check("parity_valid_later", valid, 0);
      issue(KEY_A, 1'b0, 16);
      finish_run(16);

      // START with another key mid-run is ignored.
      issue(KEY_A, 1'b0, 16);
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      key = KEY_B;
      decrypt = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b0;
      finish_run(-1);

      // Reset after the 5th accepted subkey, then a fresh run.
      begin
         int cyc;
         issue(KEY_A, 1'b0, 5);
         cyc = 0;
         while ((accepts - run_base) < 5 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
         end
         check("five_accepts", accepts - run_base, 5);
         reset_n = 1'b0;
         @(posedge clk);
         #1;
         check("midreset_valid", valid, 0);
         check("midreset_busy", busy, 0);
         check("midreset_subkey", subkey, 0);
         check("midreset_round", round, 0);
         reset_n = 1'b1;
         check("midreset_queue", exp_q.size(), 0);
         @(posedge clk);
         #1;
      end
      issue(KEY_A, 1'b0, 16);
      finish_run(16);

      repeat (3) @(posedge clk);
      #1;
      check("done_pulse_count", done_pulses, 6);
      check("key_err_pulse_count", key_err_pulses, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
Sequential DES key-schedule generator that sits directly upstream of the DES round datapath (encrypt and decrypt). It latches a 64-bit key, applies PC-1, and emits one 48-bit round subkey per handshake (PC-2 of the rotated C/D halves). Subkeys are issued in K1..K16 order for encryption and K16..K1 order for decryption. A valid/ready handshake lets an iterative round engine consume subkeys at its own pace.

Parameters:
PARITY_CHECK, 0, 1 = reject keys whose bytes are not all odd-parity (KEY_ERR); 0 = ignore parity bits.

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET_N  input  1  synchronous active-low reset
START  input  1  request a new schedule; sampled only in IDLE
KEY  input  64  DES key including parity bits; latched on accepted START
DECRYPT  input  1  latched with START; 0 = K1..K16 order, 1 = K16..K1 order
SUBKEY  output  48  current round subkey, PC-2 output, MSB = PC-2 bit 1
SUBKEY_VALID  output  1  SUBKEY/ROUND hold a valid subkey
SUBKEY_READY  input  1  consumer accepts SUBKEY this cycle when VALID=1
ROUND  output  4  index of the issued subkey minus 1 (K1 -> 0, K16 -> 15)
BUSY  output  1  high from accepted START until DONE
DONE  output  1  one-cycle pulse after the 16th subkey is accepted
KEY_ERR  output  1  one-cycle pulse: START rejected for parity (PARITY_CHECK=1 only)

Behaviour:
- Reset (RESET_N=0 at a rising edge): state IDLE; SUBKEY=0, SUBKEY_VALID=0, ROUND=0, BUSY=0, DONE=0, KEY_ERR=0, C/D registers = 0, counter = 0. Reset overrides everything, including mid-schedule; the partial schedule is discarded.
- States: IDLE, RUN.
- IDLE with START=1:
  - PARITY_CHECK=1 and any KEY byte has even parity: KEY_ERR=1 for the next cycle only; stay IDLE.
  - Otherwise: C/D = PC-1(KEY) (28+28 bits); latch DECRYPT; go to RUN; BUSY=1 next cycle.
- Shift schedule S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (28-bit rotations).
- Encrypt: round r subkey uses C/D rotated left by S[1]+..+S[r]. The first subkey applies S[1] to PC-1 output.
- Decrypt: the first subkey is K16, which uses the unrotated PC-1 output (total rotation 28). Each subsequent subkey K(17-r), for r = 2..16, rotates the previous C/D right by S[18-r].
- Latency: SUBKEY_VALID=1 with the first subkey on the cycle after the accepted START (1-cycle latency).
- Handshake:
  - SUBKEY, ROUND and SUBKEY_VALID are registered and held stable while VALID=1 and READY=0.
  - On VALID & READY at a clock edge, the next subkey appears the following cycle, so back-to-back acceptance gives one subkey per cycle.
  - READY is ignored when VALID=0.
- Completion: when subkey 16 is accepted, next cycle SUBKEY_VALID=0, BUSY=0, DONE=1 (one cycle), state IDLE. SUBKEY and ROUND hold their last value.
- START during RUN is ignored; KEY and DECRYPT changes during RUN have no effect.
- START in the same cycle as DONE is accepted, because state is already IDLE.
- The counter cannot wrap: exactly 16 subkeys are issued per START.

Test Plan:
- Reset, then START with KEY=133457799BBCDFF1, DECRYPT=0, READY=1 -> VALID rises 1 cycle later; SUBKEY=1B02EFFC7072 (ROUND 0), then 79AED9DBC9E5 (ROUND 1), ..., CB3D8B0E17F5 (ROUND 15); DONE pulses once; 16 consecutive valid cycles.
- Same key, DECRYPT=1 -> first SUBKEY=CB3D8B0E17F5 (ROUND 15), last=1B02EFFC7072 (ROUND 0); the sequence is the exact reverse of the encrypt run.
- Random READY stalls (READY low 0-5 cycles) -> SUBKEY and ROUND stable during stall; the sequence is identical to the first test; exactly 16 accepts.
- PARITY_CHECK=1: START with KEY=0000000000000000 -> KEY_ERR=1 for 1 cycle, BUSY stays 0, no VALID. Then KEY=133457799BBCDFF1 (all bytes odd parity) -> normal run, KEY_ERR=0.
- START asserted again mid-run with a different key -> ignored; remaining subkeys belong to the first key.
- RESET_N low after the 5th subkey -> next cycle VALID=0, BUSY=0, SUBKEY=0. A fresh START then yields 1B02EFFC7072 first.
